// File: rtl/eq_band_mixer.sv
// eq_band_mixer
// -----------------------------------------------------------------------------
// Output stage of the per-band biquad equalizer bank. A rising edge on i_next
// starts a sample: the block waits SETTLE cycles for the band filters to
// settle. It then sums the Q15 band outputs one band per cycle. The sum is
// scaled by the master attenuation shift, converted to 16-bit PCM and pushed
// into a 2-entry output FIFO that feeds the DAC serializer.
//
// Build option:
//   EQ_MIX_SAT_EN  defined   -> PCM saturates to [-32768, 32767] and o_clip
//                               pulses on the push cycle of a clamped sample.
//                  undefined -> PCM is the low 16 bits (two's-complement wrap)
//                               and o_clip is tied 0.
//
// Ports:
//   i_clk        system clock
//   i_rst        synchronous, active-high reset
//   i_next       sample strobe (rising edge starts a sample)
//   i_bands      N_BANDS x 32-bit signed Q15 band outputs, band k at [k*32 +: 32]
//   i_shift      master attenuation, arithmetic right shift 0..7
//   o_data       signed 16-bit PCM sample (head of the output FIFO)
//   o_valid      o_data holds a buffered sample
//   i_ready      downstream accepts the sample
//   o_clip       pulse during the push cycle of a saturated sample
//   o_overrun    sticky: a finished sample was dropped because the FIFO was full
//   o_missed     sticky: an i_next edge arrived while not idle
//   o_dbg_state  current FSM state (0 idle, 1 wait, 2 accumulate)
//
// Handshake: a sample transfers on every clock edge where o_valid && i_ready
// are both high. o_data is stable while o_valid && !i_ready. o_valid never
// drops without a transfer.
// -----------------------------------------------------------------------------
module eq_band_mixer #(
  parameter int N_BANDS = 8,
  parameter int SETTLE  = 40,
  parameter int Q_FP    = 15
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_next,
  input  logic [N_BANDS*32-1:0]  i_bands,
  input  logic [2:0]             i_shift,
  output logic [15:0]            o_data,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic                   o_clip,
  output logic                   o_overrun,
  output logic                   o_missed,
  output logic [1:0]             o_dbg_state
);

  localparam int ACC_W = 32 + $clog2(N_BANDS);
  localparam int IDX_W = (N_BANDS > 1) ? $clog2(N_BANDS) : 1;
  localparam int CNT_W = $clog2(SETTLE + 1);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BANDS - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SETTLE - 1);

  localparam logic signed [ACC_W-1:0] PCM_MAX = 32767;
  localparam logic signed [ACC_W-1:0] PCM_MIN = -32768;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACC  = 2'd2
  } state_t;

  state_t                   r_state;
  logic                     r_next_d;
  logic [CNT_W-1:0]         r_cnt;
  logic [IDX_W-1:0]         r_idx;
  logic signed [ACC_W-1:0]  r_acc;
  logic                     r_missed;

  logic [15:0]              r_mem [0:1];
  logic                     r_rd;
  logic                     r_wr;
  logic [1:0]               r_count;
  logic                     r_overrun;

  logic                     w_edge;
  logic signed [31:0]       w_band;
  logic signed [ACC_W-1:0]  w_band_x;
  logic signed [ACC_W-1:0]  w_sum;
  logic signed [ACC_W-1:0]  w_v;
  logic [15:0]              w_pcm;
  logic                     w_clip;
  logic                     w_push;
  logic                     w_pop;
  logic                     w_full;
  logic                     w_wr_ok;

  assign w_edge = i_next & ~r_next_d;

  // Select the band addressed by the accumulate index.
  always_comb begin
    w_band = '0;
    for (int k = 0; k < N_BANDS; k++) begin
      if (r_idx == IDX_W'(k)) w_band = i_bands[k*32 +: 32];
    end
  end

  // Signed size cast sign-extends the band into accumulator width.
  assign w_band_x = ACC_W'(w_band);
  assign w_sum    = r_acc + w_band_x;

  // Both shifts are arithmetic, i.e. floor division by powers of two.
  assign w_v = (w_sum >>> Q_FP) >>> i_shift;

`ifdef EQ_MIX_SAT_EN
  always_comb begin
    w_pcm  = 16'(w_v);
    w_clip = 1'b0;
    if (w_v > PCM_MAX) begin
      w_pcm  = 16'h7FFF;
      w_clip = 1'b1;
    end else if (w_v < PCM_MIN) begin
      w_pcm  = 16'h8000;
      w_clip = 1'b1;
    end
  end
`else
  assign w_pcm  = 16'(w_v);
  assign w_clip = 1'b0;
`endif

  // The push is the last accumulate cycle; the converted value uses the sum
  // including the final band, so it never passes through r_acc.
  assign w_push = (r_state == S_ACC) && (r_idx == LAST_IDX);
  assign o_clip = w_push & w_clip;

  // Sequencer: idle -> settle wait -> one band per cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_next_d <= 1'b0;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_acc    <= '0;
      r_missed <= 1'b0;
    end else begin
      r_next_d <= i_next;
      case (r_state)
        S_IDLE: begin
          if (w_edge) begin
            r_state <= S_WAIT;
            r_cnt   <= '0;
          end
        end
        S_WAIT: begin
          if (w_edge) r_missed <= 1'b1;
          if (r_cnt == LAST_CNT) begin
            r_state <= S_ACC;
            r_idx   <= '0;
            r_acc   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_ACC: begin
          if (w_edge) r_missed <= 1'b1;
          r_acc <= w_sum;
          if (r_idx == LAST_IDX) begin
            r_state <= S_IDLE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Output FIFO. When full, a simultaneous pop frees the head slot, which is
  // exactly the slot the write pointer addresses, so the push can land there.
  assign w_pop   = (r_count != 2'd0) && i_ready;
  assign w_full  = (r_count == 2'd2);
  assign w_wr_ok = w_push && (!w_full || w_pop);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mem[0]  <= '0;
      r_mem[1]  <= '0;
      r_rd      <= 1'b0;
      r_wr      <= 1'b0;
      r_count   <= 2'd0;
      r_overrun <= 1'b0;
    end else begin
      if (w_wr_ok) begin
        r_mem[r_wr] <= w_pcm;
        r_wr        <= ~r_wr;
      end
      if (w_pop) r_rd <= ~r_rd;
      case ({w_wr_ok, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
      if (w_push && w_full && !w_pop) r_overrun <= 1'b1;
    end
  end

  assign o_data      = r_mem[r_rd];
  assign o_valid     = (r_count != 2'd0);
  assign o_overrun   = r_overrun;
  assign o_missed    = r_missed;
  assign o_dbg_state = r_state;

endmodule
